// File: rtl/flopr32_pkg.sv
// Shared datapath constants for the MIPS register slices.
// DATA_WIDTH  : word width used by all datapath registers
// RESET_VALUE : value every datapath register takes on reset
package flopr32_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [DATA_WIDTH-1:0] RESET_VALUE = DATA_WIDTH'(32'h0000_0000);

endpackage : flopr32_pkg

// File: rtl/flopr_param.sv
// Generic resettable D flip-flop bank.
// Ports:
//   clk_in : rising-edge clock
//   rst_in : asynchronous active-low reset, loads RESET_VALUE
//   d      : data captured on every rising clk_in edge
//   q      : registered copy of d
module flopr_param #(
    parameter int unsigned       WIDTH       = 32,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    // Reset has priority over a coincident rising edge.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule : flopr_param

// File: rtl/flopr32.sv
// 32-bit resettable datapath register; thin wrapper over flopr_param.
// Ports:
//   clk_in : rising-edge clock
//   rst_in : asynchronous active-low reset
//   d      : 32-bit data in
//   q      : 32-bit registered data out
module flopr32
    import flopr32_pkg::*;
#(
    parameter int unsigned       WIDTH       = DATA_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VALUE = flopr32_pkg::RESET_VALUE
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    flopr_param #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_reg (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d      (d),
        .q      (q)
    );

endmodule : flopr32

// File: tb/tb_flopr32.sv
// Directed bench for flopr32: clock edges are driven explicitly so that
// rising-only, falling-only and mid-cycle reset cases can be isolated.
module tb_flopr32;

    logic        clk_in;
    logic        rst_in;
    logic [31:0] d;
    logic [31:0] q;

    int unsigned n_checks;
    int unsigned n_fail;

    flopr32 dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d      (d),
        .q      (q)
    );

    task automatic check(input string tag, input logic [31:0] exp);
        n_checks++;
        assert (q === exp) else begin
            n_fail++;
            $error("FAIL %s: q=%h expected %h", tag, q, exp);
        end
    endtask

    // Rising edge, then settle before sampling.
    task automatic rise();
        #4 clk_in = 1'b1;
        #1;
    endtask

    // Falling edge, then settle before sampling.
    task automatic fall();
        #4 clk_in = 1'b0;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clk_in   = 1'b0;
        rst_in   = 1'b0;
        d        = 32'hFFFF_FFFF;
        #1;
        check("reset_initial", 32'h0000_0000);

        // Rising edges ignored while reset held
        rise(); check("reset_rise1", 32'h0000_0000);
        fall(); check("reset_fall1", 32'h0000_0000);
        rise(); check("reset_rise2", 32'h0000_0000);
        fall(); check("reset_fall2", 32'h0000_0000);

        // Release without an edge keeps reset value
        rst_in = 1'b1;
        d      = 32'h7FFF_FFFF;
        #1;     check("release_no_edge", 32'h0000_0000);
        rise(); check("release_first_edge", 32'h7FFF_FFFF);

        // Capture and hold between edges
        d = 32'hDEAD_BEEF;
        fall(); check("fall_no_capture", 32'h7FFF_FFFF);
        rise(); check("capture_deadbeef", 32'hDEAD_BEEF);
        d = 32'h1234_5678;
        #1;     check("hold_high_phase", 32'hDEAD_BEEF);
        fall(); check("hold_low_phase", 32'hDEAD_BEEF);
        rise(); check("capture_12345678", 32'h1234_5678);

        // Mid-cycle async reset with clock stable high
        d = 32'hA5A5_A5A5;
        fall();
        rise(); check("capture_a5a5a5a5", 32'hA5A5_A5A5);
        rst_in = 1'b0;
        #1;     check("async_reset_mid", 32'h0000_0000);
        d = 32'h5A5A_5A5A;
        fall();
        rise(); check("edge_during_reset", 32'h0000_0000);

        // Falling edge only has no effect
        rst_in = 1'b1;
        d      = 32'h0000_0001;
        fall();
        rise(); check("capture_one", 32'h0000_0001);
        d = 32'h8000_0000;
        fall(); check("falling_only", 32'h0000_0001);

        // Coincident rising edge and reset assertion: reset wins
        d = 32'hCAFE_F00D;
        #4;
        clk_in = 1'b1;
        rst_in = 1'b0;
        #1;     check("reset_wins_edge", 32'h0000_0000);
        rst_in = 1'b1;
        #1;     check("release_clk_high", 32'h0000_0000);
        fall(); check("release_fall", 32'h0000_0000);
        rise(); check("capture_cafef00d", 32'hCAFE_F00D);

        // Independent bit capture across patterns
        d = 32'h5555_5555; fall(); rise(); check("pattern_5555", 32'h5555_5555);
        d = 32'hAAAA_AAAA; fall(); rise(); check("pattern_aaaa", 32'hAAAA_AAAA);
        d = 32'h8000_0001; fall(); rise(); check("pattern_msb_lsb", 32'h8000_0001);
        d = 32'hFFFF_FFFF; fall(); rise(); check("pattern_ones", 32'hFFFF_FFFF);
        d = 32'h0000_0000; fall(); rise(); check("pattern_zeros", 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_flopr32

// File: doc/flopr32.md
FLOPR32 -- requirements
Module: flopr32

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits; SHALL be fixed at 32 for flopr32.
REQ-002 Parameter RESET_VALUE, default 32'h0000_0000: value loaded into q on reset.
REQ-003 clk_in  input  1  clock; the only clock, all state updates on its rising edge.
REQ-004 rst_in  input  1  reset; asynchronous, active-low.
REQ-005 d  input  32 (WIDTH)  data captured on each rising clk_in edge.
REQ-006 q  output  32 (WIDTH)  registered copy of d; driven directly from the register, no output logic.
REQ-007 The module SHALL have one clock and an asynchronous, active-low reset; no other ports.

Function
REQ-008 On each rising edge of clk_in with rst_in high, q SHALL take the value of d sampled at that edge; latency exactly one edge.
REQ-009 Between rising edges, q SHALL hold its value regardless of changes on d.
REQ-010 Falling edges of clk_in SHALL have no effect on q.
REQ-011 All 32 bits SHALL be captured independently; no arithmetic, masking, sign or width conversion.
REQ-012 d containing X/Z SHALL propagate unchanged to q at the capturing edge (no X-filtering).
REQ-013 q SHALL never be combinationally dependent on d.

Reset
REQ-014 When rst_in is low, q SHALL become RESET_VALUE (all zeros) immediately, without waiting for a clock edge.
REQ-015 While rst_in is low, q SHALL stay at RESET_VALUE; rising clk_in edges SHALL be ignored.
REQ-016 Reset asserted mid-cycle (between edges) SHALL clear q at once; the previously captured value is lost.
REQ-017 Simultaneous rising clk_in edge and rst_in low SHALL yield q = RESET_VALUE (reset wins).
REQ-018 After rst_in returns high, the first rising clk_in edge SHALL load d; until then q SHALL remain RESET_VALUE.
REQ-019 q SHALL be undefined only before the first reset or first capturing edge after power-up.

Structure
REQ-020 WIDTH default and RESET_VALUE default SHALL be shared constants in the project package (e.g. DATA_WIDTH = 32) so the MIPS datapath registers use the same values.
REQ-021 flopr32 SHALL be a thin wrapper instantiating one generic sub-module, flopr_param (parameters WIDTH, RESET_VALUE), which holds the single sequential process.
REQ-022 Sub-module SHALL contain exactly one always_ff block sensitive to posedge clk_in and negedge rst_in; no latches, no combinational feedback.
REQ-023 No enable, no synchronous clear, no scan logic in this block.

Verification
REQ-024 Reset: rst_in=0, d=32'hFFFF_FFFF, toggle clk_in twice -> q=32'h0000_0000 throughout.
REQ-025 Capture: rst_in=1, d=32'hDEAD_BEEF, rising clk_in -> q=32'hDEAD_BEEF after that edge; change d to 32'h1234_5678 before next edge -> q still 32'hDEAD_BEEF until the next rising edge, then 32'h1234_5678.
REQ-026 Async reset mid-cycle: q=32'hA5A5_A5A5, drive rst_in low with clk_in stable -> q=32'h0000_0000 within the same time step, no clock edge needed.
REQ-027 Falling edge: q=32'h0000_0001, d=32'h8000_0000, falling clk_in only -> q remains 32'h0000_0001.
REQ-028 Reset release: rst_in 0->1, d=32'h7FFF_FFFF, no edge -> q=0; next rising clk_in -> q=32'h7FFF_FFFF.
REQ-029 Bench SHALL apply vectors {clk_in, rst_in, d, expected q} from a table and compare q with !== at the opposite phase of the bench clock, counting mismatches and reporting total vectors and errors at end.
